// File: rtl/mem_port_arbiter.sv
// Shares one combinational-read memory port between the multicycle core and a host requester.
// The core is frozen while the host owns the port; host bursts are bounded so the core keeps making progress.
module mem_port_arbiter #(
    parameter int MAX_HOST_BURST  = 16,
    parameter int CORE_MIN_CYCLES = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ena,
    input  logic        i_core_halted,
    output logic        o_core_ena,
    input  logic [31:0] i_core_mem_addr,
    input  logic [31:0] i_core_mem_wr_data,
    input  logic        i_core_mem_wr_ena,
    output logic [31:0] o_core_mem_rd_data,
    input  logic        i_host_req,
    input  logic        i_host_we,
    input  logic [31:0] i_host_addr,
    input  logic [31:0] i_host_wdata,
    output logic        o_host_gnt,
    output logic [31:0] o_host_rdata,
    output logic        o_host_rvalid,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wr_data,
    output logic        o_mem_wr_ena,
    input  logic [31:0] i_mem_rd_data,
    output logic        o_owner,
    output logic [31:0] o_stall_cycles
);

    localparam int CMIN     = (CORE_MIN_CYCLES == 0) ? 1 : CORE_MIN_CYCLES;
    localparam int BW       = (MAX_HOST_BURST > 0) ? $clog2(MAX_HOST_BURST + 1) : 1;
    localparam int CW       = $clog2(CMIN + 1);
    localparam bit LIMIT_EN = (MAX_HOST_BURST != 0);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_HOST_BURST);
    localparam logic [CW-1:0] COOL_LAST = CW'(CMIN - 1);

    typedef enum logic [1:0] {
        S_CORE     = 2'd0,
        S_HOST     = 2'd1,
        S_COOLDOWN = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [BW-1:0] r_burst_cnt;
    logic [BW-1:0] w_burst_next;
    logic [BW-1:0] w_burst_inc;
    logic [CW-1:0] r_cool_cnt;
    logic [CW-1:0] w_cool_next;
    logic [31:0]   r_host_rdata;
    logic          r_host_rvalid;
    logic [31:0]   r_stall_cycles;

    // Saturates at the limit so a halted core (unlimited burst) can never wrap the count.
    assign w_burst_inc = (r_burst_cnt == BURST_MAX) ? r_burst_cnt : r_burst_cnt + 1'b1;

    always_comb begin
        w_state_next = r_state;
        w_burst_next = r_burst_cnt;
        w_cool_next  = r_cool_cnt;
        if (i_ena) begin
            case (r_state)
                S_CORE: begin
                    if (i_host_req) begin
                        w_state_next = S_HOST;
                        w_burst_next = '0;
                    end
                end
                S_HOST: begin
                    if (!i_host_req) begin
                        w_state_next = S_CORE;
                        w_burst_next = '0;
                    end else if (LIMIT_EN && !i_core_halted && (w_burst_inc == BURST_MAX)) begin
                        w_state_next = S_COOLDOWN;
                        w_burst_next = '0;
                        w_cool_next  = '0;
                    end else begin
                        w_burst_next = w_burst_inc;
                    end
                end
                S_COOLDOWN: begin
                    if (r_cool_cnt == COOL_LAST) begin
                        w_state_next = S_CORE;
                        w_cool_next  = '0;
                    end else begin
                        w_cool_next = r_cool_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_next = S_CORE;
                    w_burst_next = '0;
                    w_cool_next  = '0;
                end
            endcase
        end
    end

    // Port steering. Reset forces the port quiet immediately, without waiting for a clock.
    always_comb begin
        o_core_ena    = 1'b0;
        o_host_gnt    = 1'b0;
        o_mem_wr_ena  = 1'b0;
        o_owner       = 1'b0;
        o_mem_addr    = i_core_mem_addr;
        o_mem_wr_data = i_core_mem_wr_data;
        if (!i_rst_n) begin
            o_mem_addr    = '0;
            o_mem_wr_data = '0;
        end else begin
            case (r_state)
                S_HOST: begin
                    o_owner       = 1'b1;
                    o_mem_addr    = i_host_addr;
                    o_mem_wr_data = i_host_wdata;
                    o_host_gnt    = i_ena & i_host_req;
                    o_mem_wr_ena  = i_ena & i_host_req & i_host_we;
                end
                default: begin
                    // A store held by a frozen core only reaches memory once core_ena is back.
                    o_core_ena   = i_ena;
                    o_mem_wr_ena = i_ena & i_core_mem_wr_ena;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_CORE;
            r_burst_cnt    <= '0;
            r_cool_cnt     <= '0;
            r_host_rdata   <= '0;
            r_host_rvalid  <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_state     <= w_state_next;
            r_burst_cnt <= w_burst_next;
            r_cool_cnt  <= w_cool_next;
            if (o_host_gnt && !i_host_we) begin
                r_host_rdata  <= i_mem_rd_data;
                r_host_rvalid <= 1'b1;
            end else begin
                r_host_rvalid <= 1'b0;
            end
            if (i_ena && !o_core_ena) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign o_core_mem_rd_data = i_mem_rd_data;
    assign o_host_rdata       = r_host_rdata;
    assign o_host_rvalid      = r_host_rvalid;
    assign o_stall_cycles     = r_stall_cycles;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table plus hand-written
// multi-cycle sequences (bursts, cooldown, frozen stores, ena gating, async reset).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic        core_halted = 1'b0;
    logic        core_ena;
    logic [31:0] core_addr = 32'h0;
    logic [31:0] core_wdata = 32'h0;
    logic        core_wr = 1'b0;
    logic [31:0] core_rdata;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [31:0] host_addr = 32'h0;
    logic [31:0] host_wdata = 32'h0;
    logic        host_gnt;
    logic [31:0] host_rdata;
    logic        host_rvalid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr_ena;
    logic [31:0] mem_rd_data;
    logic        owner;
    logic [31:0] stall_cycles;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:255];
    int          wr80_cnt = 0;

    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_wr_ena) begin
            mem[mem_addr[9:2]] <= mem_wr_data;
            if (mem_addr == 32'h80) wr80_cnt <= wr80_cnt + 1;
        end
    end

    mem_port_arbiter #(.MAX_HOST_BURST(16), .CORE_MIN_CYCLES(4)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_ena(ena),
        .i_core_halted(core_halted),
        .o_core_ena(core_ena),
        .i_core_mem_addr(core_addr),
        .i_core_mem_wr_data(core_wdata),
        .i_core_mem_wr_ena(core_wr),
        .o_core_mem_rd_data(core_rdata),
        .i_host_req(host_req),
        .i_host_we(host_we),
        .i_host_addr(host_addr),
        .i_host_wdata(host_wdata),
        .o_host_gnt(host_gnt),
        .o_host_rdata(host_rdata),
        .o_host_rvalid(host_rvalid),
        .o_mem_addr(mem_addr),
        .o_mem_wr_data(mem_wr_data),
        .o_mem_wr_ena(mem_wr_ena),
        .i_mem_rd_data(mem_rd_data),
        .o_owner(owner),
        .o_stall_cycles(stall_cycles)
    );

    typedef struct packed {
        logic rst_n;
        logic ena;
        logic halted;
        logic req;
        logic we;
        logic cwr;
        logic e_core_ena;
        logic e_gnt;
        logic e_owner;
        logic e_wr;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ena = 1'b0;
        core_halted = 1'b0;
        host_req = 1'b0;
        host_we = 1'b0;
        core_wr = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int gcount;
        logic [31:0] s0;
        int w0;
        logic exp_g;

        //                rst ena hlt req we cwr | cena gnt own wr
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        core_addr  = 32'h40;
        core_wdata = 32'h11;
        host_addr  = 32'h100;
        host_wdata = 32'hDEADBEEF;
        tick();

        // Table-driven per-cycle vectors
        for (int i = 0; i < 10; i++) begin
            rst_n       = vecs[i].rst_n;
            ena         = vecs[i].ena;
            core_halted = vecs[i].halted;
            host_req    = vecs[i].req;
            host_we     = vecs[i].we;
            core_wr     = vecs[i].cwr;
            @(negedge clk);
            chk($sformatf("vec%0d core_ena", i), {31'b0, core_ena}, {31'b0, vecs[i].e_core_ena});
            chk($sformatf("vec%0d host_gnt", i), {31'b0, host_gnt}, {31'b0, vecs[i].e_gnt});
            chk($sformatf("vec%0d owner", i), {31'b0, owner}, {31'b0, vecs[i].e_owner});
            chk($sformatf("vec%0d mem_wr_ena", i), {31'b0, mem_wr_ena}, {31'b0, vecs[i].e_wr});
            $display("vector %0d applied", i);
            tick();
        end

        // Host write then read back, stall count
        do_reset();
        @(negedge clk);
        chk("reset stall_cycles", stall_cycles, 32'd0);
        chk("reset host_rvalid", {31'b0, host_rvalid}, 32'd0);
        chk("reset host_rdata", host_rdata, 32'd0);
        tick();
        core_addr = 32'h40;
        host_addr = 32'h100;
        host_wdata = 32'hDEADBEEF;
        ena = 1'b1;
        host_req = 1'b1;
        host_we = 1'b1;
        @(negedge clk);
        chk("wr_rd decision core_ena", {31'b0, core_ena}, 32'd1);
        chk("wr_rd decision gnt", {31'b0, host_gnt}, 32'd0);
        tick();
        @(negedge clk);
        chk("wr gnt", {31'b0, host_gnt}, 32'd1);
        chk("wr mem_wr_ena", {31'b0, mem_wr_ena}, 32'd1);
        chk("wr mem_addr", mem_addr, 32'h100);
        chk("wr core_ena", {31'b0, core_ena}, 32'd0);
        tick();
        host_we = 1'b0;
        @(negedge clk);
        chk("rd gnt", {31'b0, host_gnt}, 32'd1);
        chk("rd mem_wr_ena", {31'b0, mem_wr_ena}, 32'd0);
        tick();
        host_req = 1'b0;
        @(negedge clk);
        chk("rd rvalid", {31'b0, host_rvalid}, 32'd1);
        chk("rd rdata", host_rdata, 32'hDEADBEEF);
        chk("idle gnt", {31'b0, host_gnt}, 32'd0);
        chk("idle core_ena", {31'b0, core_ena}, 32'd0);
        tick();
        @(negedge clk);
        chk("after rvalid", {31'b0, host_rvalid}, 32'd0);
        chk("resume core_ena", {31'b0, core_ena}, 32'd1);
        chk("stall_cycles", stall_cycles, 32'd3);
        $display("write/read sequence done");

        // Bounded burst with cooldown: period of 21 cycles (decision, 16 grants, 4 cooldown)
        do_reset();
        ena = 1'b1;
        host_req = 1'b1;
        host_we = 1'b0;
        gcount = 0;
        for (int c = 0; c <= 50; c++) begin
            exp_g = ((c % 21) >= 1) && ((c % 21) <= 16);
            @(negedge clk);
            chk($sformatf("burst c%0d gnt", c), {31'b0, host_gnt}, {31'b0, exp_g});
            chk($sformatf("burst c%0d core_ena", c), {31'b0, core_ena}, {31'b0, ~exp_g});
            if (host_gnt) gcount++;
            tick();
        end
        chk("burst total grants", gcount, 32'd40);
        $display("bounded burst sequence done, grants=%0d", gcount);

        // Halted core: unlimited burst, then limit reapplies once halted drops
        do_reset();
        ena = 1'b1;
        core_halted = 1'b1;
        host_req = 1'b1;
        gcount = 0;
        for (int c = 0; c <= 40; c++) begin
            exp_g = (c >= 1);
            @(negedge clk);
            chk($sformatf("halted c%0d gnt", c), {31'b0, host_gnt}, {31'b0, exp_g});
            if (host_gnt) gcount++;
            tick();
        end
        chk("halted total grants", gcount, 32'd40);
        core_halted = 1'b0;
        @(negedge clk);
        chk("unhalt last gnt", {31'b0, host_gnt}, 32'd1);
        tick();
        @(negedge clk);
        chk("unhalt cooldown gnt", {31'b0, host_gnt}, 32'd0);
        chk("unhalt cooldown core_ena", {31'b0, core_ena}, 32'd1);
        host_req = 1'b0;
        $display("halted burst sequence done, grants=%0d", gcount);

        // Core store held while frozen must be written exactly once after resume
        do_reset();
        w0 = wr80_cnt;
        ena = 1'b1;
        core_addr = 32'h80;
        core_wdata = 32'h55;
        core_wr = 1'b0;
        host_addr = 32'h100;
        host_we = 1'b0;
        host_req = 1'b1;
        tick();
        core_wr = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            chk($sformatf("frozen store c%0d wr_ena", c), {31'b0, mem_wr_ena}, 32'd0);
            chk($sformatf("frozen store c%0d owner", c), {31'b0, owner}, 32'd1);
            tick();
        end
        host_req = 1'b0;
        @(negedge clk);
        chk("frozen store idle wr_ena", {31'b0, mem_wr_ena}, 32'd0);
        tick();
        @(negedge clk);
        chk("resume store wr_ena", {31'b0, mem_wr_ena}, 32'd1);
        chk("resume store addr", mem_addr, 32'h80);
        tick();
        core_wr = 1'b0;
        @(negedge clk);
        chk("store write count", wr80_cnt - w0, 32'd1);
        chk("store mem value", mem[8'h20], 32'h55);
        $display("frozen store sequence done");

        // ena=0 freezes grants and stall counter
        do_reset();
        ena = 1'b1;
        host_req = 1'b1;
        host_we = 1'b0;
        tick();
        tick();
        ena = 1'b0;
        s0 = stall_cycles;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("ena0 c%0d gnt", c), {31'b0, host_gnt}, 32'd0);
            chk($sformatf("ena0 c%0d core_ena", c), {31'b0, core_ena}, 32'd0);
            tick();
        end
        @(negedge clk);
        chk("ena0 stall held", stall_cycles, s0);
        tick();
        ena = 1'b1;
        @(negedge clk);
        chk("ena1 gnt resumes", {31'b0, host_gnt}, 32'd1);
        tick();
        $display("ena gating sequence done");

        // Asynchronous reset in the middle of a host write
        do_reset();
        ena = 1'b1;
        host_req = 1'b1;
        host_we = 1'b0;
        host_addr = 32'h100;
        tick();
        tick();
        host_we = 1'b1;
        host_wdata = 32'h12345678;
        @(negedge clk);
        chk("pre-reset rvalid", {31'b0, host_rvalid}, 32'd1);
        chk("pre-reset wr_ena", {31'b0, mem_wr_ena}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset wr_ena", {31'b0, mem_wr_ena}, 32'd0);
        chk("async reset owner", {31'b0, owner}, 32'd0);
        chk("async reset rvalid", {31'b0, host_rvalid}, 32'd0);
        chk("async reset mem_addr", mem_addr, 32'd0);
        chk("async reset gnt", {31'b0, host_gnt}, 32'd0);
        tick();
        rst_n = 1'b1;
        host_req = 1'b0;
        tick();
        $display("async reset sequence done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
